// File: rtl/dmem_hs.sv
// Handshaked word-organised data memory with byte/half/word access, load extension,
// store lane merge, programmable latency and a sequential clear after reset.
module dmem_hs #(
    parameter int unsigned DEPTH          = 4096,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned LATENCY        = 1,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter bit          TRACE          = 1'b1
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_pc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   clear_ptr_q, clear_ptr_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               we_q;
    logic [1:0]         size_q;
    logic               signed_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        pc_q;

    logic [31:0]        mem [DEPTH];

    logic               accept, commit, mem_we;
    logic [IDX_W-1:0]   idx, mem_waddr;
    logic [1:0]         lane;
    logic               oor, bad;
    logic [31:0]        old_word, merged, load_val, mem_wdata;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;

    assign idx  = addr_q[IDX_W+1:2];
    assign lane = addr_q[1:0];
    assign oor  = (addr_q >> (IDX_W + 2)) != '0;

    // Decode, load extraction and store merge all work on the latched request.
    always_comb begin
        case (size_q)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lane[0];
            2'b10:   bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        bad = bad | oor;

        old_word = mem[idx];
        ld_byte  = old_word[{lane, 3'b000} +: 8];
        ld_half  = lane[1] ? old_word[31:16] : old_word[15:0];

        case (size_q)
            2'b00:   load_val = signed_q ? {{24{ld_byte[7]}}, ld_byte} : {24'b0, ld_byte};
            2'b01:   load_val = signed_q ? {{16{ld_half[15]}}, ld_half} : {16'b0, ld_half};
            default: load_val = old_word;
        endcase

        merged = old_word;
        case (size_q)
            2'b00:   merged[{lane, 3'b000} +: 8]  = wdata_q[7:0];
            2'b01:   merged[{lane[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        accept      = 1'b0;
        commit      = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = idx;
        mem_wdata   = merged;

        case (state_q)
            CLEAR: begin
                mem_we      = 1'b1;
                mem_waddr   = clear_ptr_q;
                mem_wdata   = '0;
                clear_ptr_d = clear_ptr_q + 1'b1;
                if (clear_ptr_q == IDX_W'(DEPTH - 1)) state_d = IDLE;
            end
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    err_d   = bad;
                    rdata_d = (bad || we_q) ? '0 : load_val;
                    if (we_q && !bad) begin
                        commit = 1'b1;
                        mem_we = 1'b1;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q     <= CLEAR_ON_RESET ? CLEAR : IDLE;
            clear_ptr_q <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (accept) begin
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            pc_q     <= req_pc;
        end
    end

    // Reset wins over both the clear sweep and a store due at the same edge.
    always_ff @(posedge Clk) begin
        if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
    end

    generate
        if (TRACE) begin : g_trace
            always_ff @(posedge Clk) begin
                if (commit && !reset)
                    $display("%0t@%h: *%h <= %h", $time, pc_q, {addr_q[ADDR_W-1:2], 2'b00}, merged);
            end
        end
    endgenerate

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_hs.sv
// Bench for dmem_hs: transaction-level memory model with a per-cycle output checker,
// directed literal cases, randomized traffic and a reset-abort check on a second instance.
module tb_dmem_hs;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned LAT   = 3;

    logic        clk;
    logic        rst_a, rst_b;

    logic        a_req_valid, a_req_ready, a_req_we, a_req_signed;
    logic [1:0]  a_req_size;
    logic [31:0] a_req_addr, a_req_wdata, a_req_pc;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_we, b_req_signed;
    logic [1:0]  b_req_size;
    logic [31:0] b_req_addr, b_req_wdata, b_req_pc;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    logic [31:0] model_mem [DEPTH];
    bit          chk_en  = 1'b0;
    bit          busy    = 1'b0;
    int          acc_cyc = 0;
    logic [31:0] exp_rdata = '0;
    logic        exp_err   = 1'b0;

    dmem_hs #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(LAT), .CLEAR_ON_RESET(1'b1), .TRACE(1'b0)) u_a (
        .Clk(clk), .reset(rst_a),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_size(a_req_size), .req_signed(a_req_signed), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .req_pc(a_req_pc),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    dmem_hs #(.DEPTH(DEPTH), .ADDR_W(32), .LATENCY(LAT), .CLEAR_ON_RESET(1'b0), .TRACE(1'b1)) u_b (
        .Clk(clk), .reset(rst_b),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_size(b_req_size), .req_signed(b_req_signed), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .req_pc(b_req_pc),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Reference: byte-addressed view of a word array, plain arithmetic only.
    function automatic void model_access(input logic we, input logic [1:0] size, input logic sgn,
                                         input logic [31:0] addr, input logic [31:0] wdata,
                                         output logic [31:0] rdata, output logic err);
        int unsigned sh, wi;
        logic [31:0] word, mask, v;
        err = (size == 2'b11) || (size == 2'b01 && addr % 2 != 0) ||
              (size == 2'b10 && addr % 4 != 0) || (addr >= DEPTH * 4);
        rdata = '0;
        if (err) return;
        wi   = addr / 4;
        sh   = (addr % 4) * 8;
        word = model_mem[wi];
        if (size == 2'b00)      mask = 32'h0000_00FF << sh;
        else if (size == 2'b01) mask = 32'h0000_FFFF << sh;
        else                    mask = 32'hFFFF_FFFF;
        if (we) begin
            model_mem[wi] = (word & ~mask) | ((wdata << sh) & mask);
        end else begin
            v = (word & mask) >> sh;
            if (sgn && size == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
            if (sgn && size == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
            rdata = v;
        end
    endfunction

    // Per-cycle output check of instance A against the model's timing and data.
    always @(negedge clk) begin : cmp
        bit v;
        if (chk_en) begin
            if (!busy) begin
                check("idle_req_ready", {31'b0, a_req_ready}, 32'd1);
                check("idle_rsp_valid", {31'b0, a_rsp_valid}, 32'd0);
                check("idle_rsp_rdata", a_rsp_rdata, 32'd0);
                check("idle_rsp_err",   {31'b0, a_rsp_err},   32'd0);
            end else begin
                v = (cyc - acc_cyc) >= LAT;
                check("busy_req_ready", {31'b0, a_req_ready}, 32'd0);
                check("busy_rsp_valid", {31'b0, a_rsp_valid}, {31'b0, v});
                check("busy_rsp_rdata", a_rsp_rdata, v ? exp_rdata : 32'd0);
                check("busy_rsp_err",   {31'b0, a_rsp_err},   {31'b0, v ? exp_err : 1'b0});
            end
        end
    end

    task automatic a_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input int unsigned stall,
                         output logic [31:0] got_rdata, output logic got_err, output int lat);
        logic [31:0] er;
        logic        ee;
        int unsigned w;
        model_access(we, size, sgn, addr, wdata, er, ee);
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = we; a_req_size = size; a_req_signed = sgn;
        a_req_addr = addr; a_req_wdata = wdata; a_req_pc = $urandom;
        @(posedge clk); #1;
        exp_rdata = er; exp_err = ee; acc_cyc = cyc; busy = 1'b1;
        a_req_valid = 1'b0; a_req_addr = $urandom; a_req_wdata = $urandom;
        a_req_size = 2'($urandom); a_req_we = 1'($urandom); a_req_signed = 1'($urandom);
        w = 0;
        @(negedge clk);
        while (!a_rsp_valid && w < 20) begin
            w++;
            @(negedge clk);
        end
        lat = cyc - acc_cyc;
        if (!a_rsp_valid) check("a_rsp_timeout", {31'b0, a_rsp_valid}, 32'd1);
        got_rdata = a_rsp_rdata;
        got_err   = a_rsp_err;
        repeat (stall) @(negedge clk);
        a_rsp_ready = 1'b1;
        @(posedge clk); #1;
        busy = 1'b0;
        a_rsp_ready = 1'b0;
    endtask

    task automatic b_req(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] got_rdata,
                         output logic got_err, output int lat);
        int acc, w;
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = we; b_req_size = size; b_req_signed = 1'b0;
        b_req_addr = addr; b_req_wdata = wdata; b_req_pc = 32'h0000_1000 + addr;
        @(posedge clk); #1;
        acc = cyc;
        b_req_valid = 1'b0;
        w = 0;
        @(negedge clk);
        while (!b_rsp_valid && w < 20) begin
            w++;
            @(negedge clk);
        end
        lat = cyc - acc;
        if (!b_rsp_valid) check("b_rsp_timeout", {31'b0, b_rsp_valid}, 32'd1);
        got_rdata = b_rsp_rdata;
        got_err   = b_rsp_err;
        b_rsp_ready = 1'b1;
        @(posedge clk); #1;
        b_rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_er;
        string       name;
    } dir_t;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] rd;
        logic        er;
        int          lat, cnt;
        dir_t        dir [$];

        rst_a = 1'b1; rst_b = 1'b1;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_size = 2'b10; a_req_signed = 1'b0;
        a_req_addr = '0; a_req_wdata = '0; a_req_pc = '0; a_rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_size = 2'b10; b_req_signed = 1'b0;
        b_req_addr = '0; b_req_wdata = '0; b_req_pc = '0; b_rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        check("a_rsp_valid_after_reset", {31'b0, a_rsp_valid}, 32'd0);
        check("a_rsp_rdata_after_reset", a_rsp_rdata, 32'd0);
        check("b_ready_no_clear", {31'b0, b_req_ready}, 32'd1);
        cnt = 0;
        while (!a_req_ready && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("clear_cycles", cnt, 32'd16);
        chk_en = 1'b1;

        // Directed cases with hand-computed results.
        dir.push_back('{1'b0, 2'b10, 1'b0, 32'h3C, 32'h0,        32'h0000_0000, 1'b0, "lw_3c_cleared"});
        dir.push_back('{1'b1, 2'b10, 1'b0, 32'h08, 32'h11223344, 32'h0000_0000, 1'b0, "sw_8"});
        dir.push_back('{1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        32'h1122_3344, 1'b0, "lw_8"});
        dir.push_back('{1'b1, 2'b00, 1'b0, 32'h09, 32'hFFFF_FFAB, 32'h0000_0000, 1'b0, "sb_9"});
        dir.push_back('{1'b0, 2'b00, 1'b1, 32'h09, 32'h0,        32'hFFFF_FFAB, 1'b0, "lb_9"});
        dir.push_back('{1'b0, 2'b00, 1'b0, 32'h09, 32'h0,        32'h0000_00AB, 1'b0, "lbu_9"});
        dir.push_back('{1'b0, 2'b01, 1'b1, 32'h0A, 32'h0,        32'h0000_1122, 1'b0, "lh_a"});
        dir.push_back('{1'b0, 2'b01, 1'b0, 32'h0A, 32'h0,        32'h0000_1122, 1'b0, "lhu_a"});
        dir.push_back('{1'b1, 2'b01, 1'b0, 32'h05, 32'h5555_5555, 32'h0000_0000, 1'b1, "sh_5_misaligned"});
        dir.push_back('{1'b1, 2'b10, 1'b0, 32'h06, 32'h6666_6666, 32'h0000_0000, 1'b1, "sw_6_misaligned"});
        dir.push_back('{1'b1, 2'b11, 1'b0, 32'h08, 32'h7777_7777, 32'h0000_0000, 1'b1, "size11_8"});
        dir.push_back('{1'b0, 2'b10, 1'b0, 32'h40, 32'h0,        32'h0000_0000, 1'b1, "lw_40_oor"});
        dir.push_back('{1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        32'h1122_AB44, 1'b0, "lw_8_after_errs"});
        foreach (dir[i]) begin
            a_req(dir[i].we, dir[i].size, dir[i].sgn, dir[i].addr, dir[i].wdata, 0, rd, er, lat);
            check({dir[i].name, "_rdata"}, rd, dir[i].exp_rd);
            check({dir[i].name, "_err"}, {31'b0, er}, {31'b0, dir[i].exp_er});
            if (i < 3) check({dir[i].name, "_latency"}, lat, LAT);
        end

        // Held-off consumer: the per-cycle checker covers stability during the stall.
        a_req(1'b0, 2'b00, 1'b1, 32'h0B, 32'h0, 5, rd, er, lat);
        check("stall_lb_b_rdata", rd, 32'h0000_0011);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] addr;
            if ($urandom_range(0, 9) == 0) addr = $urandom;
            else                           addr = $urandom_range(0, DEPTH * 4 - 1);
            a_req(1'($urandom), 2'($urandom), 1'($urandom), addr, $urandom,
                  $urandom_range(0, 3), rd, er, lat);
        end
        chk_en = 1'b0;

        // Instance B: reset during the first wait cycle must abandon the store.
        b_req(1'b1, 2'b10, 32'h0, 32'h0BAD_F00D, rd, er, lat);
        check("b_sw_pre_err", {31'b0, er}, 32'd0);
        check("b_sw_pre_latency", lat, LAT);
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_size = 2'b10;
        b_req_addr = 32'h0; b_req_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        @(negedge clk);
        check("b_wait_ready", {31'b0, b_req_ready}, 32'd0);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("b_abort_rsp_valid", {31'b0, b_rsp_valid}, 32'd0);
            check("b_abort_req_ready", {31'b0, b_req_ready}, 32'd1);
            @(negedge clk);
        end
        b_req(1'b0, 2'b10, 32'h0, 32'h0, rd, er, lat);
        check("b_lw_after_abort", rd, 32'h0BAD_F00D);
        check("b_lw_after_abort_err", {31'b0, er}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
